// File: rtl/video_pkg.sv
// Shared definitions for the video sink/source blocks: sync polarities,
// the measurement state encoding and the timing tuple record.
package video_pkg;

    localparam logic SYNC_ACTIVE  = 1'b1;
    localparam logic BLANK_ACTIVE = 1'b1;

    // Default counter width of the timing tuple exchanged with timing generators.
    localparam int TIMING_CNT_SZ = 12;

    typedef struct packed {
        logic [TIMING_CNT_SZ-1:0] h_total;
        logic [TIMING_CNT_SZ-1:0] h_active;
        logic [TIMING_CNT_SZ-1:0] hsync_len;
        logic [TIMING_CNT_SZ-1:0] v_total;
        logic [TIMING_CNT_SZ-1:0] v_active;
        logic [TIMING_CNT_SZ-1:0] vsync_len;
    } timing_t;

    typedef enum logic {
        MEAS_ARM = 1'b0,
        MEAS_RUN = 1'b1
    } meas_state_t;

endpackage

// File: rtl/video_edge_detect.sv
// Input register plus one-cycle-delayed copy; rise/fall are decoded between
// the registered value and its delayed copy.
module video_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic q_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q   <= 1'b0;
            q_d <= 1'b0;
        end else begin
            q   <= d;
            q_d <= q;
        end
    end

    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/video_timing_meas.sv
// Sink-side video timing monitor: measures line/frame geometry, sums active
// pixels per frame and reports lock once consecutive frames agree.
module video_timing_meas #(
    parameter int PIX_SZ      = 8,
    parameter int CNT_SZ      = 12,
    parameter int SUM_SZ      = 32,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_blank,
    input  logic              i_vsync,
    input  logic              i_hsync,
    input  logic [PIX_SZ-1:0] i_r,
    input  logic [PIX_SZ-1:0] i_g,
    input  logic [PIX_SZ-1:0] i_b,
    output logic [CNT_SZ-1:0] o_h_total,
    output logic [CNT_SZ-1:0] o_h_active,
    output logic [CNT_SZ-1:0] o_hsync_len,
    output logic [CNT_SZ-1:0] o_v_total,
    output logic [CNT_SZ-1:0] o_v_active,
    output logic [CNT_SZ-1:0] o_vsync_len,
    output logic [SUM_SZ-1:0] o_frame_sum,
    output logic              o_valid,
    output logic              o_locked,
    output logic              o_err
);

    import video_pkg::*;

    localparam int         TUP_SZ = 6 * CNT_SZ;
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    function automatic logic [CNT_SZ-1:0] sat_inc(input logic [CNT_SZ-1:0] v);
        return (&v) ? v : v + CNT_SZ'(1);
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (&v) ? v : v + 4'd1;
    endfunction

    // ---- stage p0: registered inputs and sync edges ----
    logic hs_q, hs_rise, hs_fall;
    logic vs_q, vs_rise, vs_fall;
    logic bl_q, bl_rise, bl_fall;

    video_edge_detect u_hsync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .d       (i_hsync == SYNC_ACTIVE),
        .q       (hs_q),
        .rise    (hs_rise),
        .fall    (hs_fall)
    );

    video_edge_detect u_vsync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .d       (i_vsync == SYNC_ACTIVE),
        .q       (vs_q),
        .rise    (vs_rise),
        .fall    (vs_fall)
    );

    video_edge_detect u_blank (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .d       (i_blank == BLANK_ACTIVE),
        .q       (bl_q),
        .rise    (bl_rise),
        .fall    (bl_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{vs_fall, bl_rise, bl_fall};

    logic [PIX_SZ-1:0] r_p0, g_p0, b_p0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_p0 <= '0;
            g_p0 <= '0;
            b_p0 <= '0;
        end else begin
            r_p0 <= i_r;
            g_p0 <= i_g;
            b_p0 <= i_b;
        end
    end

    logic              active_p0;
    logic [PIX_SZ+1:0] pix_p0;

    assign active_p0 = ~bl_q;
    assign pix_p0    = (PIX_SZ+2)'(r_p0) + (PIX_SZ+2)'(g_p0) + (PIX_SZ+2)'(b_p0);

    // Line domain: the cycle carrying the hsync rise still belongs to the ending line.
    logic [CNT_SZ-1:0] h_cnt, act_cnt, hs_cnt;
    logic [CNT_SZ-1:0] line_total, line_active, hsync_len;
    logic [CNT_SZ-1:0] tot_close, act_close;

    assign tot_close = sat_inc(h_cnt);
    assign act_close = active_p0 ? sat_inc(act_cnt) : act_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt       <= '0;
            act_cnt     <= '0;
            hs_cnt      <= '0;
            line_total  <= '0;
            line_active <= '0;
            hsync_len   <= '0;
        end else begin
            h_cnt   <= hs_rise ? '0 : tot_close;
            act_cnt <= hs_rise ? '0 : act_close;
            if (hs_rise) begin
                line_total  <= tot_close;
                line_active <= act_close;
            end
            if (hs_fall) begin
                hsync_len <= hs_cnt;
                hs_cnt    <= '0;
            end else if (hs_q) begin
                hs_cnt <= sat_inc(hs_cnt);
            end
        end
    end

    // Frame domain: *_nxt already include this cycle's line close so that a
    // coincident hsync/vsync rise is counted in the ending frame.
    logic [CNT_SZ-1:0] line_cnt, vact_cnt, vsl_cnt;
    logic [CNT_SZ-1:0] line_nxt, vact_nxt, vsl_nxt;
    logic [SUM_SZ-1:0] acc, acc_nxt;
    logic              ovf, ovf_nxt, sat_evt;

    assign line_nxt = hs_rise ? sat_inc(line_cnt) : line_cnt;
    assign vact_nxt = (hs_rise && act_close != '0) ? sat_inc(vact_cnt) : vact_cnt;
    assign vsl_nxt  = (hs_rise && vs_q) ? sat_inc(vsl_cnt) : vsl_cnt;
    assign acc_nxt  = active_p0 ? acc + SUM_SZ'(pix_p0) : acc;

    assign sat_evt = (&h_cnt)
                   | (active_p0 & (&act_cnt))
                   | (hs_q & (&hs_cnt))
                   | (hs_rise & ((&line_cnt) | (&vact_cnt) | (&vsl_cnt)));
    assign ovf_nxt = ovf | sat_evt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            line_cnt <= '0;
            vact_cnt <= '0;
            vsl_cnt  <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
        end else if (vs_rise) begin
            line_cnt <= '0;
            vact_cnt <= '0;
            vsl_cnt  <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
        end else begin
            line_cnt <= line_nxt;
            vact_cnt <= vact_nxt;
            vsl_cnt  <= vsl_nxt;
            acc      <= acc_nxt;
            ovf      <= ovf_nxt;
        end
    end

    // The first vsync rise after reset only arms measurement.
    meas_state_t state_q, state_d;
    logic        publish;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= MEAS_ARM;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        publish = 1'b0;
        case (state_q)
            MEAS_ARM: if (vs_rise) state_d = MEAS_RUN;
            MEAS_RUN: publish = vs_rise;
            default:  state_d = MEAS_ARM;
        endcase
    end

    logic [CNT_SZ-1:0] tot_now, act_now, hsl_now;

    assign tot_now = hs_rise ? tot_close : line_total;
    assign act_now = hs_rise ? act_close : line_active;
    assign hsl_now = hs_fall ? hs_cnt : hsync_len;

    // ---- stage p1: frame snapshot ----
    logic [TUP_SZ-1:0] tup_p1;
    logic [SUM_SZ-1:0] sum_p1;
    logic              ovf_p1;
    logic              vld_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tup_p1 <= '0;
            sum_p1 <= '0;
            ovf_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= publish;
            if (publish) begin
                tup_p1 <= {tot_now, act_now, hsl_now, line_nxt, vact_nxt, vsl_nxt};
                sum_p1 <= acc_nxt;
                ovf_p1 <= ovf_nxt;
            end
        end
    end

    // ---- stage p2: published outputs and lock tracking ----
    logic [TUP_SZ-1:0] cur_tup;
    logic [3:0]        match_cnt, match_inc;
    logic              has_prev;
    logic              same_p1;

    assign cur_tup   = {o_h_total, o_h_active, o_hsync_len, o_v_total, o_v_active, o_vsync_len};
    assign match_inc = sat_inc4(match_cnt);
    assign same_p1   = (tup_p1 == cur_tup) && !ovf_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {o_h_total, o_h_active, o_hsync_len, o_v_total, o_v_active, o_vsync_len} <= '0;
            o_frame_sum <= '0;
            o_valid     <= 1'b0;
            o_locked    <= 1'b0;
            o_err       <= 1'b0;
            match_cnt   <= '0;
            has_prev    <= 1'b0;
        end else begin
            o_valid <= vld_p1;
            o_err   <= 1'b0;
            if (vld_p1) begin
                {o_h_total, o_h_active, o_hsync_len, o_v_total, o_v_active, o_vsync_len} <= tup_p1;
                o_frame_sum <= sum_p1;
                has_prev    <= 1'b1;
                if (has_prev) begin
                    if (same_p1) begin
                        match_cnt <= match_inc;
                        if (match_inc >= LOCK_N) o_locked <= 1'b1;
                    end else begin
                        match_cnt <= '0;
                        o_locked  <= 1'b0;
                        o_err     <= o_locked;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_meas.sv
// Directed stream bench: frames are generated line by line, the expected
// publish for each frame is queued and a negedge monitor checks every o_valid.
`timescale 1ns/1ps
module tb_video_timing_meas;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        blank = 1'b1, vsync = 1'b0, hsync = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic [11:0] o_h_total, o_h_active, o_hsync_len, o_v_total, o_v_active, o_vsync_len;
    logic [31:0] o_frame_sum;
    logic        o_valid, o_locked, o_err;

    always #5 clk = ~clk;

    video_timing_meas #(.PIX_SZ(8), .CNT_SZ(12), .SUM_SZ(32), .LOCK_FRAMES(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_blank     (blank),
        .i_vsync     (vsync),
        .i_hsync     (hsync),
        .i_r         (r),
        .i_g         (g),
        .i_b         (b),
        .o_h_total   (o_h_total),
        .o_h_active  (o_h_active),
        .o_hsync_len (o_hsync_len),
        .o_v_total   (o_v_total),
        .o_v_active  (o_v_active),
        .o_vsync_len (o_vsync_len),
        .o_frame_sum (o_frame_sum),
        .o_valid     (o_valid),
        .o_locked    (o_locked),
        .o_err       (o_err)
    );

    typedef struct {
        int     ht, ha, hsl, vt, va, vsl;
        longint sum;
        bit     lk, er;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(int ht, int ha, int hsl, int vt, int va, int vsl,
                                longint sum, bit lk, bit er);
        exp_t e;
        e.ht = ht; e.ha = ha; e.hsl = hsl; e.vt = vt; e.va = va; e.vsl = vsl;
        e.sum = sum; e.lk = lk; e.er = er;
        return e;
    endfunction

    // Nominal frame: 24 clk lines, 4 clk hsync, 16 active, 12 lines, 2 vsync, 8 active lines.
    function automatic exp_t nrm(bit lk, bit er);
        return mk(24, 16, 4, 12, 8, 2, 7680, lk, er);
    endfunction

    // Monitor: pops one expectation per o_valid; between publishes o_err must
    // stay low and o_locked must hold.
    bit prev_lk = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_lk = 1'b0;
        end else begin
            if (o_valid) begin
                chk("expectation_pending", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("h_total",     o_h_total,   e.ht);
                    chk("h_active",    o_h_active,  e.ha);
                    chk("hsync_len",   o_hsync_len, e.hsl);
                    chk("v_total",     o_v_total,   e.vt);
                    chk("v_active",    o_v_active,  e.va);
                    chk("vsync_len",   o_vsync_len, e.vsl);
                    chk("frame_sum",   o_frame_sum, e.sum);
                    chk("locked",      o_locked,    e.lk);
                    chk("err",         o_err,       e.er);
                end
            end else begin
                chk("err_without_valid", o_err, 0);
                chk("locked_held", o_locked, prev_lk);
            end
            prev_lk = o_locked;
        end
    end

    task automatic chk_zero();
        chk("rst_h_total",   o_h_total,   0);
        chk("rst_h_active",  o_h_active,  0);
        chk("rst_hsync_len", o_hsync_len, 0);
        chk("rst_v_total",   o_v_total,   0);
        chk("rst_v_active",  o_v_active,  0);
        chk("rst_vsync_len", o_vsync_len, 0);
        chk("rst_frame_sum", o_frame_sum, 0);
        chk("rst_valid",     o_valid,     0);
        chk("rst_locked",    o_locked,    0);
        chk("rst_err",       o_err,       0);
    endtask

    task automatic cyc(input bit hs, input bit vs, input bit bl);
        @(posedge clk);
        #1;
        hsync = hs;
        vsync = vs;
        blank = bl;
        // junk colour during blanking must never reach the checksum
        r = bl ? 8'd77 : 8'd10;
        g = bl ? 8'd77 : 8'd20;
        b = bl ? 8'd77 : 8'd30;
    endtask

    // One frame of 12 lines. gap extends the last line with blanked,
    // hsync-low cycles; rst_at pulses reset for 3 cycles at that frame cycle.
    task automatic frame(input int htot, input bit blank_all, input int gap,
                         input bit push, input exp_t e, input int rst_at);
        int n = 0;
        if (push) q.push_back(e);
        for (int l = 0; l < 12; l++) begin
            int len = htot + ((l == 11) ? gap : 0);
            for (int c = 0; c < len; c++) begin
                cyc(c < 4, l < 2,
                    !(l >= 4 && !blank_all && c >= htot - 16 && c < htot));
                if (n == rst_at) begin
                    chk("queue_empty_at_reset", q.size(), 0);
                    rst_n = 1'b0;
                    #2;
                    chk_zero();
                end
                if (n == rst_at + 3) rst_n = 1'b1;
                n++;
            end
        end
    endtask

    initial begin
        exp_t none;
        none = nrm(0, 0);
        #1;
        chk_zero();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cyc(0, 0, 1);

        // baseline stream and lock acquisition
        frame(24, 0, 0, 1, nrm(0, 0), -1);
        frame(24, 0, 0, 1, nrm(0, 0), -1);
        frame(24, 0, 0, 1, nrm(1, 0), -1);
        frame(24, 0, 0, 1, nrm(1, 0), -1);
        // one 25-clock-line frame while locked, then recovery
        frame(25, 0, 0, 1, mk(25, 16, 4, 12, 8, 2, 7680, 0, 1), -1);
        frame(24, 0, 0, 1, nrm(0, 0), -1);
        frame(24, 0, 0, 1, nrm(0, 0), -1);
        frame(24, 0, 0, 1, nrm(1, 0), -1);
        // fully blanked frame
        frame(24, 1, 0, 1, mk(24, 0, 4, 12, 0, 2, 0, 0, 1), -1);
        frame(24, 0, 0, 1, nrm(0, 0), -1);
        frame(24, 0, 0, 1, nrm(0, 0), -1);
        frame(24, 0, 0, 1, nrm(1, 0), -1);
        // last line stretched past 4095 clocks: saturated, ovf frame
        frame(24, 0, 5000, 1, mk(4095, 16, 4, 12, 8, 2, 7680, 0, 1), -1);
        frame(24, 0, 0, 1, nrm(0, 0), -1);
        frame(24, 0, 0, 1, nrm(0, 0), -1);
        frame(24, 0, 0, 1, nrm(1, 0), -1);
        // reset mid-line of line 5, then re-arm and measure again
        frame(24, 0, 0, 0, none, 5 * 24 + 10);
        frame(24, 0, 0, 1, nrm(0, 0), -1);
        frame(24, 0, 0, 1, nrm(0, 0), -1);
        frame(24, 0, 0, 0, none, -1);

        repeat (10) cyc(0, 0, 1);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
